// File: rtl/program_loader.sv
// Byte-stream program loader: parses A5-framed halfword images, writes them into
// CPU program memory and validates an XOR checksum, holding the CPU off meanwhile.
module program_loader #(
    parameter logic [31:0] START_INDEX = 32'd0,
    parameter int unsigned MAX_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_len_lo;
    logic [7:0]  r_low;
    logic [7:0]  r_csum;
    logic [15:0] r_len;
    logic [15:0] r_k;
    logic        r_dl;
    logic        r_err;
    logic [15:0] r_pin;
    logic [31:0] r_idx;

    logic        w_xfer;
    logic [15:0] w_len;
    logic        w_oversize;
    logic        w_last;

    assign w_xfer     = in_valid && in_ready;
    assign w_len      = {in_data, r_len_lo};
    assign w_oversize = {1'b0, w_len} > MAX_N;
    assign w_last     = (r_k + 16'd1) == r_len;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer && in_data == 8'hA5) w_next = LEN_LO;
            LEN_LO:  if (w_xfer) w_next = LEN_HI;
            LEN_HI: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)  w_next = CHECK;
                    else if (w_oversize) w_next = IDLE;
                    else                 w_next = DATA_LO;
                end
            end
            DATA_LO: if (w_xfer) w_next = DATA_HI;
            DATA_HI: if (w_xfer) w_next = w_last ? CHECK : DATA_LO;
            CHECK:   if (w_xfer) w_next = (in_data == r_csum) ? DONE : IDLE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // in_ready is gated by rst so it reads low throughout reset
    always_comb begin
        in_ready = !rst && (r_state != DONE);
        done     = (r_state == DONE);
        cpu_hold = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_lo <= 8'd0;
            r_low    <= 8'd0;
            r_csum   <= 8'd0;
            r_len    <= 16'd0;
            r_k      <= 16'd0;
            r_dl     <= 1'b0;
            r_err    <= 1'b0;
            r_pin    <= 16'd0;
            r_idx    <= START_INDEX;
        end else if (w_xfer) begin
            case (r_state)
                IDLE: begin
                    if (in_data == 8'hA5) begin
                        r_err  <= 1'b0;
                        r_csum <= 8'd0;
                        r_k    <= 16'd0;
                    end
                end
                LEN_LO: begin
                    r_len_lo <= in_data;
                    r_csum   <= r_csum ^ in_data;
                end
                LEN_HI: begin
                    r_len  <= w_len;
                    r_csum <= r_csum ^ in_data;
                    if (w_oversize) r_err <= 1'b1;
                end
                DATA_LO: begin
                    r_low  <= in_data;
                    r_csum <= r_csum ^ in_data;
                end
                // write strobe stays high across the frame; pairs are held between halfwords
                DATA_HI: begin
                    r_pin  <= {in_data, r_low};
                    r_idx  <= START_INDEX + 32'(r_k);
                    r_k    <= r_k + 16'd1;
                    r_dl   <= 1'b1;
                    r_csum <= r_csum ^ in_data;
                end
                CHECK: begin
                    r_dl <= 1'b0;
                    if (in_data != r_csum) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign download_program  = r_dl;
    assign error             = r_err;
    assign program_in        = r_pin;
    assign instruction_index = r_idx;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (START_INDEX 10 and 0xFFFFFFFF) share one
// byte stream; a frame-position model is compared every cycle, plus literal checks.
module tb_program_loader;

    localparam logic [31:0] SA   = 32'd10;
    localparam logic [31:0] SB   = 32'hFFFF_FFFF;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        rdy_a, dl_a, hold_a, done_a, err_a;
    logic [31:0] idx_a;
    logic [15:0] pin_a;
    logic        rdy_b, dl_b, hold_b, done_b, err_b;
    logic [31:0] idx_b;
    logic [15:0] pin_b;

    always #5 clk = ~clk;

    program_loader #(.START_INDEX(SA), .MAX_WORDS(MAXW)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
        .download_program(dl_a), .instruction_index(idx_a), .program_in(pin_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a)
    );

    program_loader #(.START_INDEX(SB), .MAX_WORDS(MAXW)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .download_program(dl_b), .instruction_index(idx_b), .program_in(pin_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Frame-position model: tracks bytes accepted since the start marker
    bit          m_ok = 1'b0;
    bit          m_in_frame, m_done_pend, m_err, m_dl;
    logic [15:0] m_pin;
    logic [31:0] m_idx_a, m_idx_b;
    logic [7:0]  m_q[$];
    logic [7:0]  m_x;
    int          m_n, m_d;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_in_frame = 1'b0; m_done_pend = 1'b0; m_err = 1'b0; m_dl = 1'b0;
            m_pin = 16'd0; m_idx_a = SA; m_idx_b = SB; m_q.delete();
        end else if (m_done_pend) begin
            m_done_pend = 1'b0;
        end else if (in_valid) begin
            if (!m_in_frame) begin
                if (in_data == 8'hA5) begin
                    m_in_frame = 1'b1; m_err = 1'b0; m_q.delete();
                end
            end else begin
                m_q.push_back(in_data);
                if (m_q.size() == 2) begin
                    m_n = int'({m_q[1], m_q[0]});
                    if (m_n > MAXW) begin m_err = 1'b1; m_in_frame = 1'b0; end
                end else begin
                    m_d = m_q.size() - 2;
                    if (m_d == 2 * m_n + 1) begin
                        m_x = 8'd0;
                        for (int i = 0; i < m_q.size() - 1; i++) m_x = m_x ^ m_q[i];
                        if (m_x == in_data) m_done_pend = 1'b1;
                        else                m_err = 1'b1;
                        m_in_frame = 1'b0; m_dl = 1'b0;
                    end else if (m_d % 2 == 0) begin
                        m_pin   = {m_q[m_d + 1], m_q[m_d]};
                        m_idx_a = SA + 32'(m_d / 2 - 1);
                        m_idx_b = SB + 32'(m_d / 2 - 1);
                        m_dl    = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare and DUT write/done logging
    logic [47:0] log_a[$], log_b[$];
    int          n_done = 0;
    bit          prev_dl_a = 1'b0, prev_dl_b = 1'b0;
    logic [47:0] last_a, last_b;
    logic        m_rdy, m_hold;

    always @(negedge clk) begin
        if (m_ok) begin
            m_rdy  = !rst && !m_done_pend;
            m_hold = m_in_frame || m_done_pend;
            chk("cycle_a", 64'({rdy_a, dl_a, hold_a, done_a, err_a, pin_a, idx_a}),
                64'({m_rdy, m_dl, m_hold, m_done_pend, m_err, m_pin, m_idx_a}));
            chk("cycle_b", 64'({rdy_b, dl_b, hold_b, done_b, err_b, pin_b, idx_b}),
                64'({m_rdy, m_dl, m_hold, m_done_pend, m_err, m_pin, m_idx_b}));
            if (done_a) n_done++;
            if (dl_a && (!prev_dl_a || {idx_a, pin_a} != last_a)) log_a.push_back({idx_a, pin_a});
            if (dl_b && (!prev_dl_b || {idx_b, pin_b} != last_b)) log_b.push_back({idx_b, pin_b});
            prev_dl_a = dl_a; last_a = {idx_a, pin_a};
            prev_dl_b = dl_b; last_b = {idx_b, pin_b};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 8 && !sent; t++) begin
            if (rdy_a) sent = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(sent), 64'd1);
    endtask

    logic [7:0] frame[$];

    task automatic send_frame(input int gap);
        foreach (frame[i]) begin
            send(frame[i]);
            repeat (gap) tick();
        end
        repeat (3) tick();
    endtask

    task automatic begin_test();
        log_a.delete();
        log_b.delete();
        n_done = 0;
    endtask

    function automatic logic [47:0] ent(input logic [47:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 48'hFFFF_FFFF_FFFF;
    endfunction

    task automatic check_good(input string tag);
        chk({tag, "_logA_n"}, 64'(log_a.size()), 64'd2);
        chk({tag, "_logA0"}, 64'(ent(log_a, 0)), 64'({32'd10, 16'h2005}));
        chk({tag, "_logA1"}, 64'(ent(log_a, 1)), 64'({32'd11, 16'h1FC2}));
        chk({tag, "_logB0"}, 64'(ent(log_b, 0)), 64'({32'hFFFF_FFFF, 16'h2005}));
        chk({tag, "_logB1"}, 64'(ent(log_b, 1)), 64'({32'h0000_0000, 16'h1FC2}));
        chk({tag, "_done_n"}, 64'(n_done), 64'd1);
        chk({tag, "_err"}, 64'(err_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(rdy_a), 64'd1);
        chk("rst_outs_a", 64'({dl_a, hold_a, done_a, err_a, pin_a, idx_a}), 64'({4'b0000, 16'h0, 32'd10}));
        chk("rst_idx_b", 64'(idx_b), 64'hFFFF_FFFF);

        // noise then good frame
        begin_test();
        frame = '{8'h00, 8'hFF, 8'h13};
        send_frame(0);
        chk("noise_hold", 64'(hold_a), 64'd0);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        send_frame(0);
        check_good("good");

        // bad checksum
        begin_test();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'h00};
        send_frame(0);
        chk("bad_logA_n", 64'(log_a.size()), 64'd2);
        chk("bad_logA1", 64'(ent(log_a, 1)), 64'({32'd11, 16'h1FC2}));
        chk("bad_err", 64'(err_a), 64'd1);
        chk("bad_done_n", 64'(n_done), 64'd0);
        chk("bad_idle", 64'(hold_a), 64'd0);

        // oversize frame; start marker clears the sticky error
        begin_test();
        send(8'hA5);
        #1;
        chk("a5_clears_err", 64'(err_a), 64'd0);
        frame = '{8'h01, 8'h04};
        send_frame(0);
        chk("big_err", 64'(err_a), 64'd1);
        chk("big_no_write", 64'(log_a.size()), 64'd0);
        chk("big_idle", 64'(hold_a), 64'd0);

        // empty frame
        begin_test();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        chk("empty_done_n", 64'(n_done), 64'd1);
        chk("empty_no_write", 64'(log_a.size()), 64'd0);
        chk("empty_err", 64'(err_a), 64'd0);

        // backpressure gaps
        begin_test();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        send_frame(3);
        check_good("gaps");

        // mid-frame reset after first halfword
        begin_test();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20};
        foreach (frame[i]) send(frame[i]);
        tick();
        chk("mid_first_write", 64'(ent(log_a, 0)), 64'({32'd10, 16'h2005}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({rdy_a, dl_a, hold_a, done_a, err_a, pin_a, idx_a}),
            64'({5'b10000, 16'h0, 32'd10}));
        chk("mid_rst_done_n", 64'(n_done), 64'd0);
        begin_test();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        send_frame(0);
        check_good("after_rst");

        // start marker inside a frame is plain data
        begin_test();
        frame = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'h01};
        send_frame(0);
        chk("a5data_logA0", 64'(ent(log_a, 0)), 64'({32'd10, 16'hA5A5}));
        chk("a5data_logB0", 64'(ent(log_b, 0)), 64'({32'hFFFF_FFFF, 16'hA5A5}));
        chk("a5data_done_n", 64'(n_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
